rambus_sample_streamer: RTL and testbench

Wishbone master for a user project's rambus port. It reads a waveform table of 32-bit words out of the shared 1 kB OpenRAM, through port B of the OpenRAM wishbone wrapper, and buffers the words in a small prefetch FIFO. It then emits one sample every `rate_div+1` clocks to the consuming datapath, such as the function generator's output stage. It sits between a project's control registers and the rambus wires, and drives all rambus master signals.

---
 rtl/rambus_sample_streamer.sv | 228 ++++++++++++++++++++++
 tb/tb_rambus_sample_streamer.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_sample_streamer.sv
// rambus_sample_streamer
//   Wishbone read master on a project's rambus port. Prefetches a table of
//   32-bit words from the shared OpenRAM into a small FIFO and replays them
//   as samples, one every rate_div+1 clocks.
// Ports
//   wb_clk_i / wb_rst_i        clock and synchronous active-high reset
//   enable                     level-sensitive run request
//   start_word / end_word      inclusive table bounds (word indices, wrap 255->0)
//   loop                       repeat the table indefinitely
//   rate_div                   sample period minus one, in clocks
//   rambus_wb_*                wishbone master signals (read only)
//   sample_o / sample_valid_o  current sample and its one-cycle update strobe
//   busy_o / done_o            run in progress / non-loop run finished
//   underrun_o                 sticky: a sample tick found the FIFO empty
module rambus_sample_streamer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable,
    input  logic [7:0]  start_word,
    input  logic [7:0]  end_word,
    input  logic        loop,
    input  logic [15:0] rate_div,
    output logic        rambus_wb_clk_o,
    output logic        rambus_wb_rst_o,
    output logic        rambus_wb_cyc_o,
    output logic        rambus_wb_stb_o,
    output logic        rambus_wb_we_o,
    output logic [3:0]  rambus_wb_sel_o,
    output logic [31:0] rambus_wb_dat_o,
    output logic [9:0]  rambus_wb_adr_o,
    input  logic        rambus_wb_ack_i,
    input  logic [31:0] rambus_wb_dat_i,
    output logic [31:0] sample_o,
    output logic        sample_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        underrun_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DepthC = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StPrime, StRun, StDrain, StFinish} state_e;

    state_e state_q, state_d;

    logic [7:0]    start_q, start_d, end_q, end_d, word_ptr_q, word_ptr_d;
    logic          loop_q, loop_d, fetch_done_q, fetch_done_d, cyc_q, cyc_d;
    logic [15:0]   rate_q, rate_d, div_q, div_d;
    logic [31:0]   sample_q, sample_d;
    logic          sample_valid_q, sample_valid_d, underrun_q, underrun_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   fifo_q [FIFO_DEPTH];

    logic fetching, ack_seen, more_words, fifo_full, fifo_empty;
    logic tick, table_done, push, pop, issue;

    assign fetching   = (state_q == StPrime) || (state_q == StRun);
    assign ack_seen   = cyc_q & rambus_wb_ack_i;
    assign more_words = loop_q | ~fetch_done_q;
    assign fifo_full  = (count_q == DepthC);
    assign fifo_empty = (count_q == '0);
    assign tick       = (state_q == StRun) && (div_q == 16'd0);
    // fetch_done_q is only ever set for non-loop runs
    assign table_done = fetch_done_q & fifo_empty;
    assign push       = ack_seen & fetching;
    assign pop        = tick & ~fifo_empty;
    // cyc_q low means nothing outstanding, so count alone bounds occupancy.
    // Gating with enable keeps a new cycle from opening on the way into DRAIN.
    assign issue      = fetching & enable & ~cyc_q & ~fifo_full & more_words;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (enable) state_d = StPrime;
            StPrime: begin
                if (!enable)                        state_d = StDrain;
                else if (fifo_full || fetch_done_q) state_d = StRun;
            end
            StRun: begin
                if (!enable)        state_d = StDrain;
                else if (table_done) state_d = StFinish;
            end
            StDrain:  if (!cyc_q) state_d = StIdle;
            StFinish: if (!enable) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            StPrime, StRun, StDrain: busy_o = 1'b1;
            StFinish:                done_o = 1'b1;
            default: begin end
        endcase
    end

    // Datapath next-state
    always_comb begin
        start_d        = start_q;
        end_d          = end_q;
        loop_d         = loop_q;
        rate_d         = rate_q;
        word_ptr_d     = word_ptr_q;
        fetch_done_d   = fetch_done_q;
        cyc_d          = cyc_q;
        div_d          = div_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        underrun_d     = underrun_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;

        if (state_q == StIdle && enable) begin
            start_d      = start_word;
            end_d        = end_word;
            loop_d       = loop;
            rate_d       = rate_div;
            word_ptr_d   = start_word;
            fetch_done_d = 1'b0;
            underrun_d   = 1'b0;
        end

        // Ack closes the cycle; the next request waits at least one idle clock.
        if (ack_seen)   cyc_d = 1'b0;
        else if (issue) cyc_d = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (word_ptr_q == end_q) begin
                if (loop_q) word_ptr_d = start_q;
                else        fetch_done_d = 1'b1;
            end else begin
                word_ptr_d = word_ptr_q + 8'd1;
            end
        end

        if (state_q == StPrime)  div_d = rate_q;
        else if (state_q == StRun) div_d = (div_q == 16'd0) ? rate_q : div_q - 16'd1;

        if (pop) begin
            sample_d       = fifo_q[rd_ptr_q];
            sample_valid_d = 1'b1;
            rd_ptr_d       = rd_ptr_q + 1'b1;
        end else if (tick && !table_done) begin
            underrun_d = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Abort: once the bus is quiet, throw away whatever was prefetched.
        if (state_q == StDrain && !cyc_q) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_q        <= '0;
            end_q          <= '0;
            loop_q         <= 1'b0;
            rate_q         <= '0;
            word_ptr_q     <= '0;
            fetch_done_q   <= 1'b0;
            cyc_q          <= 1'b0;
            div_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            start_q        <= start_d;
            end_q          <= end_d;
            loop_q         <= loop_d;
            rate_q         <= rate_d;
            word_ptr_q     <= word_ptr_d;
            fetch_done_q   <= fetch_done_d;
            cyc_q          <= cyc_d;
            div_q          <= div_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // FIFO storage needs no reset; count_q qualifies every read.
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= rambus_wb_dat_i;
    end

    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = wb_rst_i;
    assign rambus_wb_cyc_o = cyc_q;
    assign rambus_wb_stb_o = cyc_q;
    assign rambus_wb_we_o  = 1'b0;
    assign rambus_wb_sel_o = 4'hF;
    assign rambus_wb_dat_o = 32'h0;
    assign rambus_wb_adr_o = {word_ptr_q, 2'b00};
    assign sample_o        = sample_q;
    assign sample_valid_o  = sample_valid_q;
    assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_rambus_sample_streamer.sv
module tb_rambus_sample_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  start_word = '0;
    logic [7:0]  end_word = '0;
    logic        loop = 1'b0;
    logic [15:0] rate_div = '0;
    logic        clk_o, rst_o, cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [9:0]  adr_o;
    logic        ack = 1'b0;
    logic [31:0] rdat = '0;
    logic [31:0] sample_o;
    logic        sample_valid_o, busy_o, done_o, underrun_o;

    logic [31:0] ram [256];
    int          slave_lat = 1;
    int          lat_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [9:0]  adr_q [$];

    always #5 clk = ~clk;

    rambus_sample_streamer #(.FIFO_DEPTH(4)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .enable          (enable),
        .start_word      (start_word),
        .end_word        (end_word),
        .loop            (loop),
        .rate_div        (rate_div),
        .rambus_wb_clk_o (clk_o),
        .rambus_wb_rst_o (rst_o),
        .rambus_wb_cyc_o (cyc_o),
        .rambus_wb_stb_o (stb_o),
        .rambus_wb_we_o  (we_o),
        .rambus_wb_sel_o (sel_o),
        .rambus_wb_dat_o (dat_o),
        .rambus_wb_adr_o (adr_o),
        .rambus_wb_ack_i (ack),
        .rambus_wb_dat_i (rdat),
        .sample_o        (sample_o),
        .sample_valid_o  (sample_valid_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .underrun_o      (underrun_o)
    );

    // OpenRAM port-B model: acks slave_lat clocks after it first sees stb.
    always @(posedge clk) begin
        if (cyc_o && stb_o && !ack) begin
            if (lat_cnt >= slave_lat - 1) begin
                ack     <= 1'b1;
                rdat    <= ram[adr_o[9:2]];
                lat_cnt <= 0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            ack     <= 1'b0;
            lat_cnt <= 0;
        end
    end

    task automatic wait_idle(input string name);
        logic idle = 1'b0;
        for (int c = 0; c < 100 && !idle; c++) begin
            @(negedge clk);
            idle = !busy_o && !cyc_o;
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL %s_idle busy=%b cyc=%b expected 0 0", name, busy_o, cyc_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cyc_o, stb_o, we_o, sel_o, dat_o, adr_o} !== {1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 10'h0}) begin
            failures++;
            $display("FAIL reset_bus cyc=%b stb=%b we=%b sel=%h dat=%h adr=%h expected 0 0 0 f 0 0",
                     cyc_o, stb_o, we_o, sel_o, dat_o, adr_o);
        end
        checks++;
        if ({sample_o, sample_valid_o, busy_o, done_o, underrun_o} !== 36'h0) begin
            failures++;
            $display("FAIL reset_status sample=%h valid=%b busy=%b done=%b underrun=%b expected all 0",
                     sample_o, sample_valid_o, busy_o, done_o, underrun_o);
        end
        checks++;
        if (rst_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_fwd rst_o=%b expected 1", rst_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rst_o !== 1'b0 || busy_o !== 1'b0 || cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release rst_o=%b busy=%b cyc=%b expected 0 0 0", rst_o, busy_o, cyc_o);
        end
    endtask

    task automatic test_single_run();
        int last_pulse = -1;
        int last_ack = -1;
        int pulses = 0;
        logic fin = 1'b0;
        logic [31:0] es;
        logic [9:0]  ea;
        for (int i = 0; i < 4; i++) begin
            ram[10 + i] = 32'hA0 + i;
            exp_q.push_back(32'hA0 + i);
            adr_q.push_back(10'((10 + i) * 4));
        end
        start_word = 8'd10; end_word = 8'd13; loop = 1'b0; rate_div = 16'd7; slave_lat = 1;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || cyc_o !== 1'b1 || stb_o !== 1'b1) begin
            failures++;
            $display("FAIL start_latency busy=%b cyc=%b stb=%b expected 1 1 1", busy_o, cyc_o, stb_o);
        end
        // Parameters are latched at start; these must be ignored.
        start_word = 8'd0; end_word = 8'd0; rate_div = 16'd2;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (cyc_o && ack) begin
                ea = (adr_q.size() != 0) ? adr_q.pop_front() : 10'h3FF;
                checks++;
                if (adr_o !== ea) begin
                    failures++;
                    $display("FAIL single_addr got=%h expected=%h", adr_o, ea);
                end
                if (last_ack >= 0) begin
                    checks++;
                    if (c - last_ack != 3) begin
                        failures++;
                        $display("FAIL single_fetch_rate gap=%0d expected=3", c - last_ack);
                    end
                end
                last_ack = c;
            end
            if (sample_valid_o) begin
                es = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (sample_o !== es) begin
                    failures++;
                    $display("FAIL single_sample got=%h expected=%h", sample_o, es);
                end
                if (last_pulse >= 0) begin
                    checks++;
                    if (c - last_pulse != 8) begin
                        failures++;
                        $display("FAIL single_spacing gap=%0d expected=8", c - last_pulse);
                    end
                end
                last_pulse = c;
                pulses++;
            end
            if (done_o) begin
                fin = 1'b1;
                checks++;
                if (c != last_pulse + 1) begin
                    failures++;
                    $display("FAIL single_done_timing done_at=%0d expected=%0d", c, last_pulse + 1);
                end
            end
            if (!fin) @(negedge clk);
        end
        checks++;
        if (!fin || pulses != 4 || exp_q.size() != 0 || adr_q.size() != 0) begin
            failures++;
            $display("FAIL single_complete done_seen=%b pulses=%0d expected 1 4 (left %0d/%0d)",
                     fin, pulses, exp_q.size(), adr_q.size());
        end
        checks++;
        if (underrun_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_flags underrun=%b busy=%b expected 0 0", underrun_o, busy_o);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL single_done_clear done=%b expected 0", done_o);
        end
        exp_q.delete();
        adr_q.delete();
    endtask

    task automatic test_wrap_loop();
        int last_pulse = -1;
        int pulses = 0;
        int ai = 0;
        logic [7:0]  w;
        logic [31:0] es;
        for (int i = 0; i < 4; i++) begin
            w = 8'(254 + i);
            ram[w] = 32'hC0DE_0000 | 32'(w);
        end
        for (int i = 0; i < 12; i++) begin
            w = 8'(254 + i % 4);
            exp_q.push_back(32'hC0DE_0000 | 32'(w));
        end
        start_word = 8'd254; end_word = 8'd1; loop = 1'b1; rate_div = 16'd3; slave_lat = 1;
        enable = 1'b1;
        for (int c = 0; c < 400 && pulses < 12; c++) begin
            @(negedge clk);
            if (cyc_o && ack) begin
                w = 8'(254 + ai % 4);
                ai++;
                checks++;
                if (adr_o !== {w, 2'b00}) begin
                    failures++;
                    $display("FAIL wrap_addr got=%h expected=%h", adr_o, {w, 2'b00});
                end
            end
            if (sample_valid_o) begin
                es = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (sample_o !== es) begin
                    failures++;
                    $display("FAIL wrap_sample got=%h expected=%h", sample_o, es);
                end
                if (last_pulse >= 0) begin
                    checks++;
                    if (c - last_pulse != 4) begin
                        failures++;
                        $display("FAIL wrap_spacing gap=%0d expected=4", c - last_pulse);
                    end
                end
                last_pulse = c;
                pulses++;
            end
        end
        checks++;
        if (pulses != 12 || done_o !== 1'b0 || underrun_o !== 1'b0) begin
            failures++;
            $display("FAIL wrap_status pulses=%0d done=%b underrun=%b expected 12 0 0",
                     pulses, done_o, underrun_o);
        end
        enable = 1'b0;
        wait_idle("wrap");
        exp_q.delete();
    endtask

    task automatic test_underrun();
        int pulses = 0;
        int acks = 0;
        logic fin = 1'b0;
        logic seen_ur = 1'b0;
        logic [31:0] last = '0;
        logic [31:0] es;
        for (int i = 0; i < 8; i++) begin
            ram[20 + i] = 32'h5500 + i;
            exp_q.push_back(32'h5500 + i);
        end
        start_word = 8'd20; end_word = 8'd27; loop = 1'b0; rate_div = 16'd0; slave_lat = 4;
        enable = 1'b1;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            if (cyc_o && ack) acks++;
            if (sample_valid_o) begin
                es = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (sample_o !== es) begin
                    failures++;
                    $display("FAIL underrun_sample got=%h expected=%h", sample_o, es);
                end
                last = es;
                pulses++;
            end
            if (underrun_o && !seen_ur) begin
                seen_ur = 1'b1;
                checks++;
                if (sample_o !== last || pulses == 0) begin
                    failures++;
                    $display("FAIL underrun_hold sample=%h expected=%h after %0d pulses",
                             sample_o, last, pulses);
                end
            end
            fin = done_o;
        end
        checks++;
        if (!fin || !seen_ur || underrun_o !== 1'b1) begin
            failures++;
            $display("FAIL underrun_flag done=%b seen=%b underrun=%b expected 1 1 1", fin, seen_ur,
                     underrun_o);
        end
        checks++;
        if (pulses != acks || pulses != 8) begin
            failures++;
            $display("FAIL underrun_count pulses=%0d acks=%0d expected 8 8", pulses, acks);
        end
        enable = 1'b0;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_abort();
        logic found = 1'b0;
        logic held = 1'b1;
        logic got_ack = 1'b0;
        int pulses = 0;
        logic [31:0] es;
        for (int i = 0; i < 8; i++) ram[40 + i] = 32'h4000 + i;
        start_word = 8'd40; end_word = 8'd47; loop = 1'b1; rate_div = 16'd2; slave_lat = 4;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (underrun_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_underrun_clear underrun=%b expected 0", underrun_o);
        end
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            found = sample_valid_o;
        end
        checks++;
        if (!found || sample_o !== 32'h4000) begin
            failures++;
            $display("FAIL abort_first_sample found=%b got=%h expected=00004000", found, sample_o);
        end
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            found = stb_o && !ack;
        end
        enable = 1'b0;
        for (int c = 0; c < 20 && !got_ack; c++) begin
            @(negedge clk);
            if (cyc_o && ack) got_ack = 1'b1;
            else if (!stb_o) held = 1'b0;
        end
        checks++;
        if (!found || !held || !got_ack) begin
            failures++;
            $display("FAIL abort_stb_held req=%b held=%b ack=%b expected 1 1 1", found, held, got_ack);
        end
        wait_idle("abort");
        exp_q.push_back(32'h4000);
        exp_q.push_back(32'h4001);
        enable = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 300 && pulses < 2; c++) begin
            @(negedge clk);
            if (cyc_o && ack && !found) begin
                found = 1'b1;
                checks++;
                if (adr_o !== 10'h0A0) begin
                    failures++;
                    $display("FAIL abort_refetch_addr got=%h expected=0a0", adr_o);
                end
            end
            if (sample_valid_o) begin
                es = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                pulses++;
                checks++;
                if (sample_o !== es) begin
                    failures++;
                    $display("FAIL abort_flush_sample got=%h expected=%h", sample_o, es);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL abort_restart pulses=%0d expected 2", pulses);
        end
        enable = 1'b0;
        wait_idle("abort2");
        exp_q.delete();
    endtask

    task automatic test_reset_mid_run();
        logic found = 1'b0;
        logic quiet = 1'b1;
        for (int i = 0; i < 4; i++) ram[60 + i] = 32'h6000 + i;
        start_word = 8'd60; end_word = 8'd63; loop = 1'b1; rate_div = 16'd1; slave_lat = 1;
        enable = 1'b1;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            found = sample_valid_o;
        end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = cyc_o && !ack;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rstmid_setup request=%b expected 1", found);
        end
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({cyc_o, stb_o, adr_o, sample_o, sample_valid_o, busy_o, done_o, underrun_o, sel_o} !==
            {1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF}) begin
            failures++;
            $display("FAIL rstmid_outputs cyc=%b adr=%h sample=%h valid=%b busy=%b done=%b ur=%b sel=%h expected reset values",
                     cyc_o, adr_o, sample_o, sample_valid_o, busy_o, done_o, underrun_o, sel_o);
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (cyc_o || sample_valid_o || busy_o || sample_o != 32'h0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL rstmid_quiet quiet=%b expected 1", quiet);
        end
    endtask

    task automatic test_one_word();
        int pulses = 0;
        int acks = 0;
        logic [31:0] es;
        ram[5] = 32'h0BAD_F00D;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h0BAD_F00D);
        start_word = 8'd5; end_word = 8'd5; loop = 1'b1; rate_div = 16'd0; slave_lat = 1;
        enable = 1'b1;
        for (int c = 0; c < 200 && (pulses < 6 || acks < 6); c++) begin
            @(negedge clk);
            if (cyc_o && ack && acks < 6) begin
                acks++;
                checks++;
                if (adr_o !== 10'h014) begin
                    failures++;
                    $display("FAIL oneword_addr got=%h expected=014", adr_o);
                end
            end
            if (sample_valid_o && pulses < 6) begin
                es = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                pulses++;
                checks++;
                if (sample_o !== es) begin
                    failures++;
                    $display("FAIL oneword_sample got=%h expected=%h", sample_o, es);
                end
            end
        end
        checks++;
        if (pulses != 6 || acks != 6 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL oneword_count pulses=%0d acks=%0d done=%b expected 6 6 0", pulses, acks, done_o);
        end
        enable = 1'b0;
        wait_idle("oneword");
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hFFFF_0000 | 32'(i);
        test_reset();
        test_single_run();
        test_wrap_loop();
        test_underrun();
        test_abort();
        test_reset_mid_run();
        test_one_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
